// File: rtl/axi_reg_slice_pkg.sv
// ----------------------------------------------------------------------------
// axi_noc_pkg
//
// Shared definitions for the AXI4 register slice on the NOC fabric:
//   - slice_mode_e  : per-channel slice flavour (bypass / full skid / light)
//   - slice_state_e : occupancy states of the full skid buffer
//   - AXI burst and response encodings
//   - helpers returning the packed payload width of each AXI channel
//
// Build option: AXI_REG_SLICE_PERF_EN (consumed by axi_slice_chan) enables
// the per-channel stall counters; this package is the same in both builds.
// ----------------------------------------------------------------------------
package axi_noc_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FULL   = 2'd1,
        SLICE_LIGHT  = 2'd2
    } slice_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } slice_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned NUM_CHAN = 5;
    localparam int unsigned CNT_W    = 32;

    // AW and AR share one layout: id, addr, len, size(3), burst(2), lock(1),
    // cache(4), prot(3), qos(4), region(4).
    function automatic int unsigned axChanWidth(input int unsigned idW,
                                                input int unsigned addrW,
                                                input int unsigned lenW);
        return idW + addrW + lenW + 3 + 2 + 1 + 4 + 3 + 4 + 4;
    endfunction

    // W carries data, one strobe bit per byte and last.
    function automatic int unsigned wChanWidth(input int unsigned dataW);
        return dataW + (dataW / 8) + 1;
    endfunction

    // B carries id and resp.
    function automatic int unsigned bChanWidth(input int unsigned idW);
        return idW + 2;
    endfunction

    // R carries id, data, resp and last.
    function automatic int unsigned rChanWidth(input int unsigned idW,
                                               input int unsigned dataW);
        return idW + dataW + 2 + 1;
    endfunction

endpackage

// File: rtl/axi_reg_slice_if.sv
// ----------------------------------------------------------------------------
// axi_reg_slice_if
//
// Full AXI4 signal bundle (AW, W, B, AR, R) with configurable widths.
//   master modport : drives AW/W/AR payload+valid, bready, rready
//   slave  modport : drives awready, wready, arready, B and R payload+valid
// The register slice uses the slave modport towards the upstream master and
// the master modport towards the downstream slave.
// ----------------------------------------------------------------------------
interface axi_reg_slice_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_reg_slice_chan.sv
// ----------------------------------------------------------------------------
// axi_slice_chan
//
// One valid/ready register slice carrying an opaque packed payload.
//   MODE 0 (bypass) : pure wires, always reports empty
//   MODE 1 (full)   : main + skid entry, 1 beat/cycle, fully registered
//   MODE 2 (light)  : single entry, ready = !valid, 1 beat per 2 cycles
//   other           : elaboration $fatal
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   srcValid_i    source valid            srcReady_o   source ready
//   srcData_i     source payload
//   sinkValid_o   sink valid              sinkReady_i  sink ready
//   sinkData_o    sink payload
//   empty_o       slice holds no beat
//   stallCnt_o    cycles with sink valid && !sink ready (saturating)
//
// Build option: AXI_REG_SLICE_PERF_EN adds the stall counter flops;
// without it stallCnt_o is tied to zero.
// ----------------------------------------------------------------------------
module axi_slice_chan
    import axi_noc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             srcValid_i,
    output logic             srcReady_o,
    input  logic [WIDTH-1:0] srcData_i,
    output logic             sinkValid_o,
    input  logic             sinkReady_i,
    output logic [WIDTH-1:0] sinkData_o,
    output logic             empty_o,
    output logic [31:0]      stallCnt_o
);

    localparam slice_mode_e ModeE = slice_mode_e'(MODE[1:0]);

    generate
        if (MODE > 32'd2) begin : gIllegal
            $fatal(1, "axi_slice_chan: MODE %0d is not a legal slice mode", MODE);
            assign srcReady_o  = 1'b0;
            assign sinkValid_o = 1'b0;
            assign sinkData_o  = '0;
            assign empty_o     = 1'b1;
        end else if (ModeE == SLICE_BYPASS) begin : gBypass
            logic unusedBypass;
            assign unusedBypass = ^{clk, rst};
            assign srcReady_o   = sinkReady_i;
            assign sinkValid_o  = srcValid_i;
            assign sinkData_o   = srcData_i;
            assign empty_o      = 1'b1;
        end else if (ModeE == SLICE_FULL) begin : gFull
            slice_state_e     state_q, state_d;
            logic [WIDTH-1:0] mainData_q, mainData_d;
            logic [WIDTH-1:0] skidData_q, skidData_d;
            logic             srcAccept, sinkAccept;

            // Both handshake outputs come straight from the state flop, so
            // neither valid nor ready has a combinational path through us.
            assign srcReady_o  = (state_q != ST_FULL);
            assign sinkValid_o = (state_q != ST_EMPTY);
            assign sinkData_o  = mainData_q;
            assign empty_o     = (state_q == ST_EMPTY);
            assign srcAccept   = srcValid_i && srcReady_o;
            assign sinkAccept  = sinkValid_o && sinkReady_i;

            // Main always holds the oldest beat; skid only fills when a beat
            // arrives while main is stalled, which keeps ordering trivial.
            always_comb begin
                state_d    = state_q;
                mainData_d = mainData_q;
                skidData_d = skidData_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (srcAccept) begin
                            state_d    = ST_ONE;
                            mainData_d = srcData_i;
                        end
                    end
                    ST_ONE: begin
                        if (srcAccept && sinkAccept) begin
                            mainData_d = srcData_i;
                        end else if (srcAccept) begin
                            state_d    = ST_FULL;
                            skidData_d = srcData_i;
                        end else if (sinkAccept) begin
                            state_d    = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (sinkAccept) begin
                            state_d    = ST_ONE;
                            mainData_d = skidData_q;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            // Payload is only meaningful while valid, so it needs no reset.
            always_ff @(posedge clk) begin
                mainData_q <= mainData_d;
                skidData_q <= skidData_d;
            end
        end else begin : gLight
            logic             valid_q, valid_d;
            logic [WIDTH-1:0] data_q, data_d;
            logic             srcAccept, sinkAccept;

            // A single entry that refuses new beats while occupied: the
            // price of no combinational path is half throughput.
            assign srcReady_o  = !valid_q;
            assign sinkValid_o = valid_q;
            assign sinkData_o  = data_q;
            assign empty_o     = !valid_q;
            assign srcAccept   = srcValid_i && srcReady_o;
            assign sinkAccept  = sinkValid_o && sinkReady_i;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (srcAccept) begin
                    valid_d = 1'b1;
                    data_d  = srcData_i;
                end else if (sinkAccept) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end
    endgenerate

`ifdef AXI_REG_SLICE_PERF_EN
    logic [31:0] stallCnt_q, stallCnt_d;

    // Count sink-side backpressure cycles; hold at all-ones instead of
    // wrapping so a long-running stall never reads as a small number.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (sinkValid_o && !sinkReady_i && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stallCnt_o = stallCnt_q;
`else
    assign stallCnt_o = '0;
`endif

endmodule

// File: rtl/axi_reg_slice.sv
// ----------------------------------------------------------------------------
// axi_reg_slice
//
// AXI4 register slice between an upstream master (s) and a downstream slave
// (m). Each of AW, W, B, AR, R is one axi_slice_chan whose mode is chosen by
// the matching *_MODE parameter (0 bypass, 1 full skid, 2 light).
//
// Ports:
//   axi_clk         clock, all state on the rising edge
//   axi_rst         asynchronous active-high reset
//   s               slave modport facing the upstream master
//   m               master modport facing the downstream slave
//   idle            registered: high when every registered slice is empty
//   perf_stall_cnt  5 x 32-bit stall counters, [AW,W,B,AR,R] from the LSB
//
// Build option: AXI_REG_SLICE_PERF_EN enables the stall counters; otherwise
// perf_stall_cnt reads zero. The port list is the same either way.
// ----------------------------------------------------------------------------
module axi_reg_slice
    import axi_noc_pkg::*;
#(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned AW_MODE = 1,
    parameter int unsigned W_MODE  = 1,
    parameter int unsigned B_MODE  = 1,
    parameter int unsigned AR_MODE = 1,
    parameter int unsigned R_MODE  = 1
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst,
    axi_reg_slice_if.slave            s,
    axi_reg_slice_if.master           m,
    output logic                      idle,
    output logic [NUM_CHAN*CNT_W-1:0] perf_stall_cnt
);

    localparam int unsigned AX_PW = axChanWidth(ID_W, ADDR_W, LEN_W);
    localparam int unsigned W_PW  = wChanWidth(DATA_W);
    localparam int unsigned B_PW  = bChanWidth(ID_W);
    localparam int unsigned R_PW  = rChanWidth(ID_W, DATA_W);

    // Bypass channels are wires, so their accepts must not disturb idle.
    localparam logic [4:0] SLICED = {R_MODE != 0, AR_MODE != 0, B_MODE != 0,
                                     W_MODE != 0, AW_MODE != 0};

    generate
        if ((DATA_W % 8) != 0) begin : gBadDataW
            $fatal(1, "axi_reg_slice: DATA_W %0d is not a multiple of 8", DATA_W);
        end
    endgenerate

    logic [AX_PW-1:0] awSrc, awSink, arSrc, arSink;
    logic [W_PW-1:0]  wSrc, wSink;
    logic [B_PW-1:0]  bSrc, bSink;
    logic [R_PW-1:0]  rSrc, rSink;
    logic [31:0]      awCnt, wCnt, bCnt, arCnt, rCnt;
    logic [4:0]       chanEmpty;
    logic [4:0]       chanAccept;
    logic             idle_q, idle_d;

    assign awSrc = {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst, s.awlock,
                    s.awcache, s.awprot, s.awqos, s.awregion};
    assign {m.awid, m.awaddr, m.awlen, m.awsize, m.awburst, m.awlock,
            m.awcache, m.awprot, m.awqos, m.awregion} = awSink;

    assign wSrc = {s.wdata, s.wstrb, s.wlast};
    assign {m.wdata, m.wstrb, m.wlast} = wSink;

    assign bSrc = {m.bid, m.bresp};
    assign {s.bid, s.bresp} = bSink;

    assign arSrc = {s.arid, s.araddr, s.arlen, s.arsize, s.arburst, s.arlock,
                    s.arcache, s.arprot, s.arqos, s.arregion};
    assign {m.arid, m.araddr, m.arlen, m.arsize, m.arburst, m.arlock,
            m.arcache, m.arprot, m.arqos, m.arregion} = arSink;

    assign rSrc = {m.rid, m.rdata, m.rresp, m.rlast};
    assign {s.rid, s.rdata, s.rresp, s.rlast} = rSink;

    axi_slice_chan #(.WIDTH(AX_PW), .MODE(AW_MODE)) uAwSlice (
        .clk(axi_clk), .rst(axi_rst),
        .srcValid_i(s.awvalid), .srcReady_o(s.awready), .srcData_i(awSrc),
        .sinkValid_o(m.awvalid), .sinkReady_i(m.awready), .sinkData_o(awSink),
        .empty_o(chanEmpty[0]), .stallCnt_o(awCnt)
    );

    axi_slice_chan #(.WIDTH(W_PW), .MODE(W_MODE)) uWSlice (
        .clk(axi_clk), .rst(axi_rst),
        .srcValid_i(s.wvalid), .srcReady_o(s.wready), .srcData_i(wSrc),
        .sinkValid_o(m.wvalid), .sinkReady_i(m.wready), .sinkData_o(wSink),
        .empty_o(chanEmpty[1]), .stallCnt_o(wCnt)
    );

    axi_slice_chan #(.WIDTH(B_PW), .MODE(B_MODE)) uBSlice (
        .clk(axi_clk), .rst(axi_rst),
        .srcValid_i(m.bvalid), .srcReady_o(m.bready), .srcData_i(bSrc),
        .sinkValid_o(s.bvalid), .sinkReady_i(s.bready), .sinkData_o(bSink),
        .empty_o(chanEmpty[2]), .stallCnt_o(bCnt)
    );

    axi_slice_chan #(.WIDTH(AX_PW), .MODE(AR_MODE)) uArSlice (
        .clk(axi_clk), .rst(axi_rst),
        .srcValid_i(s.arvalid), .srcReady_o(s.arready), .srcData_i(arSrc),
        .sinkValid_o(m.arvalid), .sinkReady_i(m.arready), .sinkData_o(arSink),
        .empty_o(chanEmpty[3]), .stallCnt_o(arCnt)
    );

    axi_slice_chan #(.WIDTH(R_PW), .MODE(R_MODE)) uRSlice (
        .clk(axi_clk), .rst(axi_rst),
        .srcValid_i(m.rvalid), .srcReady_o(m.rready), .srcData_i(rSrc),
        .sinkValid_o(s.rvalid), .sinkReady_i(s.rready), .sinkData_o(rSink),
        .empty_o(chanEmpty[4]), .stallCnt_o(rCnt)
    );

    assign perf_stall_cnt = {rCnt, arCnt, bCnt, wCnt, awCnt};

    assign chanAccept = {m.rvalid && m.rready, s.arvalid && s.arready,
                         m.bvalid && m.bready, s.wvalid && s.wready,
                         s.awvalid && s.awready};

    // Looking at the accepts as well as the occupancy lets idle fall in the
    // cycle right after a beat enters, not one cycle later.
    always_comb begin
        idle_d = (&chanEmpty) && !(|(chanAccept & SLICED));
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            idle_q <= 1'b1;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign idle = idle_q;

endmodule
